// File: rtl/qspi_flash_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_flash_pkg
//  Description : Shared opcodes, FSM state encoding and defaults for the
//                behavioural quad-SPI NOR flash model.
//  Revision    : 1.0 - initial release
// ============================================================================
package qspi_flash_pkg;

    localparam logic [7:0] OP_QWRITE = 8'h32;
    localparam logic [7:0] OP_QREAD  = 8'h6B;
    localparam logic [7:0] OP_SERASE = 8'h20;

    localparam logic [3:0] ERASE_VAL_DEFAULT = 4'hF;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CMD        = 3'd1,
        ADDR       = 3'd2,
        WRITE      = 3'd3,
        READ       = 3'd4,
        ERASE_WAIT = 3'd5,
        IGNORE     = 3'd6
    } qspi_state_t;

endpackage
`default_nettype wire

// File: rtl/qspi_flash_sync.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_flash_sync
//  Description : Two-flop synchronizers for the QSPI pins plus a rise/fall
//                pulse generator on the synchronized serial clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_flash_sync #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_qspi_clk,
    input  logic              i_qspi_cs_b,
    input  logic              i_qspi_rst_b,
    input  logic [DATA_W-1:0] i_qspi_io,
    output logic              o_cs_b,
    output logic              o_rst_b,
    output logic [DATA_W-1:0] o_io,
    output logic              o_clk_rise,
    output logic              o_clk_fall
);

    localparam int c_W = DATA_W + 3;

    logic [c_W-1:0] w_raw;
    logic [c_W-1:0] r_meta;
    logic [c_W-1:0] r_sync;
    logic           r_clk_d;

    // Bit layout: {rst_b, cs_b, clk, io}; all lanes share one pipeline depth
    // so data and clock edges stay aligned after synchronization.
    assign w_raw = {i_qspi_rst_b, i_qspi_cs_b, i_qspi_clk, i_qspi_io};

    // Two-stage synchronizer and delayed copy of the serial clock for edge detect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta  <= '0;
            r_sync  <= '0;
            r_clk_d <= 1'b0;
        end else begin
            r_meta  <= w_raw;
            r_sync  <= r_meta;
            r_clk_d <= r_sync[DATA_W];
        end
    end

    assign o_io       = r_sync[DATA_W-1:0];
    assign o_clk_rise =  r_sync[DATA_W] & ~r_clk_d;
    assign o_clk_fall = ~r_sync[DATA_W] &  r_clk_d;
    assign o_cs_b     = r_sync[DATA_W+1];
    assign o_rst_b    = r_sync[DATA_W+2];

endmodule
`default_nettype wire

// File: rtl/qspi_flash.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_flash
//  Description : Behavioural quad-SPI NOR flash: nibble array reachable from a
//                direct host port and from a synchronized QSPI slave engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_flash
    import qspi_flash_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 4,
    parameter logic [DATA_W-1:0] ERASE_VAL = ERASE_VAL_DEFAULT,
    parameter int                SECTOR_SZ = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              QSPI_CLK,
    input  logic              QSPI_CS_b,
    input  logic              QSPI_RST_b,
    inout  wire  [DATA_W-1:0] QSPI_IO,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic              erase_enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out
);

    localparam int c_DEPTH   = 2 ** ADDR_W;
    localparam int c_SEC_LSB = $clog2(SECTOR_SZ);

    logic [DATA_W-1:0]   r_mem [c_DEPTH];
    qspi_state_t         r_state;
    logic [2*DATA_W-1:0] r_opcode;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_nib_cnt;
    logic                r_rd_first;
    logic                r_oe;
    logic [DATA_W-1:0]   r_io_out;

    logic                w_cs_b_s;
    logic                w_rst_b_s;
    logic [DATA_W-1:0]   w_io_s;
    logic                w_rise;
    logic                w_fall;
    logic                w_q_wr;
    logic                w_sec_erase;
    logic                w_host_wr;
    logic [ADDR_W-1:0]   w_ptr_next;

    qspi_flash_sync #(
        .DATA_W (DATA_W)
    ) u_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_qspi_clk   (QSPI_CLK),
        .i_qspi_cs_b  (QSPI_CS_b),
        .i_qspi_rst_b (QSPI_RST_b),
        .i_qspi_io    (QSPI_IO),
        .o_cs_b       (w_cs_b_s),
        .o_rst_b      (w_rst_b_s),
        .o_io         (w_io_s),
        .o_clk_rise   (w_rise),
        .o_clk_fall   (w_fall)
    );

    assign QSPI_IO     = r_oe ? r_io_out : {DATA_W{1'bz}};
    assign w_ptr_next  = r_ptr + 1'b1;
    assign w_host_wr   = write_enable | erase_enable;
    assign w_q_wr      = w_rst_b_s & ~w_cs_b_s & (r_state == WRITE) & w_rise;
    // Sector erase fires on the cycle the deselect is seen while armed.
    assign w_sec_erase = w_rst_b_s &  w_cs_b_s & (r_state == ERASE_WAIT);

    // QSPI protocol engine: command/address capture, burst pointer, IO drive.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_opcode   <= '0;
            r_ptr      <= '0;
            r_nib_cnt  <= 1'b0;
            r_rd_first <= 1'b0;
            r_oe       <= 1'b0;
            r_io_out   <= '0;
        end else if (!w_rst_b_s || w_cs_b_s) begin
            r_state   <= IDLE;
            r_oe      <= 1'b0;
            r_nib_cnt <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state   <= CMD;
                    r_nib_cnt <= 1'b0;
                end
                CMD: if (w_rise) begin
                    r_opcode  <= {r_opcode[DATA_W-1:0], w_io_s};
                    r_nib_cnt <= ~r_nib_cnt;
                    if (r_nib_cnt) r_state <= ADDR;
                end
                ADDR: if (w_rise) begin
                    r_ptr     <= {r_ptr[ADDR_W-DATA_W-1:0], w_io_s};
                    r_nib_cnt <= ~r_nib_cnt;
                    if (r_nib_cnt) begin
                        case (r_opcode)
                            OP_QWRITE: r_state <= WRITE;
                            OP_QREAD: begin
                                r_state    <= READ;
                                r_rd_first <= 1'b1;
                            end
                            OP_SERASE: r_state <= ERASE_WAIT;
                            default:   r_state <= IGNORE;
                        endcase
                    end
                end
                WRITE: if (w_rise) r_ptr <= w_ptr_next;
                READ: if (w_fall) begin
                    // First fall presents the addressed nibble; later falls advance.
                    r_oe <= 1'b1;
                    if (r_rd_first) begin
                        r_io_out   <= r_mem[r_ptr];
                        r_rd_first <= 1'b0;
                    end else begin
                        r_ptr    <= w_ptr_next;
                        r_io_out <= r_mem[w_ptr_next];
                    end
                end
                default: ;
            endcase
        end
    end

    // Array update; host write/erase is applied last so it overrides QSPI updates.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= ERASE_VAL;
        end else begin
            if (w_sec_erase) begin
                for (int j = 0; j < SECTOR_SZ; j++)
                    r_mem[{r_ptr[ADDR_W-1:c_SEC_LSB], j[c_SEC_LSB-1:0]}] <= ERASE_VAL;
            end
            if (w_q_wr && !w_host_wr) r_mem[r_ptr] <= w_io_s;
            if (erase_enable)      r_mem[address] <= ERASE_VAL;
            else if (write_enable) r_mem[address] <= data_in;
        end
    end

    // Registered host read port; returns pre-update contents on a same-cycle write.
    always_ff @(posedge clk) begin
        if (!reset_n)         data_out <= '0;
        else if (read_enable) data_out <= r_mem[address];
    end

endmodule
`default_nettype wire

// File: tb/tb_qspi_flash.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qspi_flash
//  Description : Scoreboard bench for qspi_flash: host and QSPI stimulus push
//                expected nibbles, independent monitors pop and compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qspi_flash;

    localparam int         HP      = 8;      // QSPI half period in clk cycles
    localparam logic [3:0] C_ERASE = 4'hF;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       QSPI_CLK = 1'b0;
    logic       QSPI_CS_b = 1'b1;
    logic       QSPI_RST_b = 1'b1;
    logic       write_enable = 1'b0;
    logic       read_enable = 1'b0;
    logic       erase_enable = 1'b0;
    logic [3:0] data_in = '0;
    logic [7:0] address = '0;
    logic [3:0] data_out;
    wire  [3:0] QSPI_IO;

    logic       tb_io_en = 1'b0;
    logic [3:0] tb_io = '0;
    logic       rd_v = 1'b0;
    logic       q_rd_active = 1'b0;

    logic [3:0] model [256];
    exp_t       exp_host[$];
    logic [3:0] exp_io[$];
    logic [3:0] wdata[$];
    int         n_tests = 0;
    int         n_fail = 0;

    assign QSPI_IO = tb_io_en ? tb_io : 4'bzzzz;
    pulldown (QSPI_IO[0]);
    pulldown (QSPI_IO[1]);
    pulldown (QSPI_IO[2]);
    pulldown (QSPI_IO[3]);

    qspi_flash dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .QSPI_CLK     (QSPI_CLK),
        .QSPI_CS_b    (QSPI_CS_b),
        .QSPI_RST_b   (QSPI_RST_b),
        .QSPI_IO      (QSPI_IO),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .erase_enable (erase_enable),
        .data_in      (data_in),
        .address      (address),
        .data_out     (data_out)
    );

    always #5 clk = ~clk;

    // data_out is valid the cycle after a sampled read strobe.
    always @(posedge clk) rd_v <= read_enable;

    // Host read monitor.
    always @(negedge clk) begin : mon_host
        exp_t e;
        if (rd_v) begin
            n_tests++;
            if (exp_host.size() == 0) begin
                n_fail++;
                $display("FAIL host_rd unexpected data_out=%h", data_out);
            end else begin
                e = exp_host.pop_front();
                if (data_out !== e.val) begin
                    n_fail++;
                    $display("FAIL host_rd addr=%h got=%h exp=%h", e.addr, data_out, e.val);
                end
            end
        end
    end

    // QSPI read monitor: master samples IO on each rising serial clock.
    always @(posedge QSPI_CLK) begin : mon_io
        logic [3:0] e;
        if (q_rd_active) begin
            n_tests++;
            if (exp_io.size() == 0) begin
                n_fail++;
                $display("FAIL qspi_rd unexpected io=%h", QSPI_IO);
            end else begin
                e = exp_io.pop_front();
                if (QSPI_IO !== e) begin
                    n_fail++;
                    $display("FAIL qspi_rd got=%h exp=%h", QSPI_IO, e);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic host_op(input logic we, input logic re, input logic er,
                           input logic [7:0] a, input logic [3:0] d);
        write_enable = we; read_enable = re; erase_enable = er;
        address = a; data_in = d;
        if (re) exp_host.push_back('{a, model[a]});
        if (er)      model[a] = C_ERASE;
        else if (we) model[a] = d;
        wait_clk(1);
        write_enable = 1'b0; read_enable = 1'b0; erase_enable = 1'b0;
    endtask

    task automatic q_nibble(input logic [3:0] d);
        tb_io = d; tb_io_en = 1'b1;
        wait_clk(HP); QSPI_CLK = 1'b1;
        wait_clk(HP); QSPI_CLK = 1'b0;
    endtask

    task automatic q_start(input logic [7:0] op, input logic [7:0] a);
        QSPI_CS_b = 1'b0; wait_clk(HP);
        q_nibble(op[7:4]); q_nibble(op[3:0]);
        q_nibble(a[7:4]);  q_nibble(a[3:0]);
    endtask

    task automatic q_end();
        wait_clk(HP);
        tb_io_en = 1'b0; QSPI_CS_b = 1'b1; QSPI_CLK = 1'b0;
        wait_clk(HP);
    endtask

    task automatic q_write(input logic [7:0] a);
        logic [7:0] p;
        p = a;
        q_start(8'h32, a);
        foreach (wdata[i]) begin
            q_nibble(wdata[i]);
            model[p] = wdata[i];
            p = p + 8'd1;
        end
        q_end();
    endtask

    task automatic q_read(input logic [7:0] a, input int n, input bit abort);
        logic [7:0] p;
        q_start(8'h6B, a);
        tb_io_en = 1'b0;
        p = a;
        for (int i = 0; i < n; i++) begin
            exp_io.push_back(model[p]);
            p = p + 8'd1;
        end
        q_rd_active = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_clk(HP); QSPI_CLK = 1'b1;
            wait_clk(HP); QSPI_CLK = 1'b0;
        end
        q_rd_active = 1'b0;
        if (abort) begin
            wait_clk(HP);
            check("io_pre_abort", QSPI_IO, model[p]);
            QSPI_CS_b = 1'b1;
            wait_clk(4);
            check("io_released_after_cs", QSPI_IO, 4'h0);
            wait_clk(HP);
        end else begin
            q_end();
        end
    endtask

    task automatic q_erase(input logic [7:0] a);
        q_start(8'h20, a);
        q_end();
        for (int i = 0; i < 16; i++) model[{a[7:4], 4'(i)}] = C_ERASE;
    endtask

    initial begin
        logic [7:0] a;
        logic [3:0] d;
        for (int i = 0; i < 256; i++) model[i] = C_ERASE;

        wait_clk(5);
        reset_n = 1'b1;
        check("reset_data_out", data_out, 4'h0);
        check("reset_io_released", QSPI_IO, 4'h0);
        wait_clk(3);

        // Erased read, write/read back, IO idle during host traffic.
        host_op(0, 1, 0, 8'h00, 4'h0);
        host_op(1, 0, 0, 8'h00, 4'hA);
        host_op(0, 1, 0, 8'h00, 4'h0);
        check("io_idle_host", QSPI_IO, 4'h0);
        host_op(1, 0, 0, 8'h10, 4'h5);
        host_op(0, 0, 1, 8'h10, 4'h0);
        host_op(0, 1, 0, 8'h10, 4'h0);
        host_op(1, 0, 1, 8'h11, 4'h6);
        host_op(0, 1, 0, 8'h11, 4'h0);
        host_op(1, 0, 0, 8'h12, 4'h7);
        host_op(1, 1, 0, 8'h12, 4'h8);   // same-cycle write returns old data
        host_op(0, 1, 0, 8'h12, 4'h0);
        check("io_idle_host2", QSPI_IO, 4'h0);

        // QSPI write with pointer wrap, then host readback.
        wdata.delete(); wdata.push_back(4'h1); wdata.push_back(4'h2); wdata.push_back(4'h3);
        q_write(8'hFE);
        host_op(0, 1, 0, 8'hFE, 4'h0);
        host_op(0, 1, 0, 8'hFF, 4'h0);
        host_op(0, 1, 0, 8'h00, 4'h0);

        // QSPI read burst with deselect mid-burst.
        q_read(8'hFE, 3, 1'b1);

        // Sector erase, then an aborted erase that must not fire.
        for (int i = 8'h2F; i <= 8'h40; i++) host_op(1, 0, 0, 8'(i), 4'(i % 15));
        q_erase(8'h37);
        for (int i = 8'h2F; i <= 8'h40; i++) host_op(0, 1, 0, 8'(i), 4'h0);
        for (int i = 8'h30; i <= 8'h3F; i++) host_op(1, 0, 0, 8'(i), 4'(i % 7));
        QSPI_CS_b = 1'b0; wait_clk(HP);
        q_nibble(4'h2); q_nibble(4'h0); q_nibble(4'h3);
        q_end();
        for (int i = 8'h30; i <= 8'h3F; i++) host_op(0, 1, 0, 8'(i), 4'h0);

        // QSPI engine reset in the middle of a write burst.
        q_start(8'h32, 8'h50);
        q_nibble(4'hA); model[8'h50] = 4'hA;
        q_nibble(4'hB); model[8'h51] = 4'hB;
        QSPI_RST_b = 1'b0; wait_clk(4);
        q_nibble(4'hC);
        tb_io_en = 1'b0; QSPI_CS_b = 1'b1; wait_clk(HP);
        QSPI_RST_b = 1'b1; wait_clk(HP);
        check("io_released_after_rst", QSPI_IO, 4'h0);
        host_op(0, 1, 0, 8'h50, 4'h0);
        host_op(0, 1, 0, 8'h51, 4'h0);
        host_op(0, 1, 0, 8'h52, 4'h0);

        // Randomized mix of host and QSPI traffic against the model.
        for (int it = 0; it < 30; it++) begin
            a = 8'($urandom);
            d = 4'($urandom);
            case ($urandom_range(0, 6))
                0: host_op(1, 0, 0, a, d);
                1: host_op(0, 1, 0, a, d);
                2: host_op(0, 0, 1, a, d);
                3: host_op(1, 1, 0, a, d);
                4: begin
                    wdata.delete();
                    repeat ($urandom_range(1, 6)) wdata.push_back(4'($urandom));
                    q_write(a);
                end
                5: q_read(a, $urandom_range(1, 6), 1'b0);
                default: q_erase(a);
            endcase
        end

        // Full array scan against the model.
        for (int i = 0; i < 256; i++) host_op(0, 1, 0, 8'(i), 4'h0);
        wait_clk(4);

        n_tests++;
        if (exp_host.size() != 0 || exp_io.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain host_left=%0d io_left=%0d exp=0",
                     exp_host.size(), exp_io.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
